// File: rtl/shift_scan_ctrl.sv
// ============================================================================
// Module      : shift_scan_ctrl
// Description : Feeds nibbles into an external 8-deep selecting shift register.
//               After each shift it scans the occupied taps out over a
//               valid/ready stream. Optional macro SCAN_OLDEST_FIRST_EN makes
//               the scan run from the oldest tap down to the newest.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_scan_ctrl #(
    parameter int DATA_W   = 4,
    parameter int DEPTH    = 8,
    parameter int SEL_W    = 3,
    parameter int SCAN_ALL = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] sr_din,
    output logic              sr_ce,
    output logic [SEL_W-1:0]  sr_count_8,
    input  logic [DATA_W-1:0] sr_selected,
    output logic [DATA_W-1:0] tap_data,
    output logic [SEL_W-1:0]  tap_idx,
    output logic              tap_valid,
    output logic              tap_last,
    input  logic              tap_ready,
    output logic [SEL_W:0]    fill_level
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam logic [SEL_W:0] C_DEPTH = (SEL_W+1)'(DEPTH);

    state_t            state_q, state_d;
    logic [SEL_W:0]    fill_q,  fill_d;
    logic [SEL_W-1:0]  idx_q,   idx_d;

    logic              w_accept;
    logic              w_tap_hs;
    logic [SEL_W:0]    w_fill_inc;
    logic [SEL_W-1:0]  w_first_idx;
    logic [SEL_W-1:0]  w_last_idx;
    logic [SEL_W-1:0]  w_step_idx;

    // in_ready is gated by RST so nothing is accepted on the reset edge itself.
    assign in_ready   = RST & (state_q == ST_IDLE);
    assign w_accept   = in_valid & in_ready;
    assign sr_ce      = w_accept;
    assign sr_din     = in_data;
    assign w_fill_inc = (fill_q == C_DEPTH) ? C_DEPTH : fill_q + 1'b1;

`ifdef SCAN_OLDEST_FIRST_EN
    logic [SEL_W:0] w_n_next;
    assign w_n_next    = (SCAN_ALL != 0) ? C_DEPTH : w_fill_inc;
    assign w_first_idx = SEL_W'(w_n_next - 1'b1);
    assign w_last_idx  = '0;
    assign w_step_idx  = idx_q - 1'b1;
`else
    logic [SEL_W:0] w_n_cur;
    assign w_n_cur     = (SCAN_ALL != 0) ? C_DEPTH : fill_q;
    assign w_first_idx = '0;
    assign w_last_idx  = SEL_W'(w_n_cur - 1'b1);
    assign w_step_idx  = idx_q + 1'b1;
`endif

    assign tap_valid  = (state_q == ST_SCAN);
    assign tap_last   = tap_valid & (idx_q == w_last_idx);
    assign tap_idx    = idx_q;
    assign tap_data   = sr_selected;
    assign sr_count_8 = tap_valid ? idx_q : '0;
    assign fill_level = fill_q;
    assign w_tap_hs   = tap_valid & tap_ready;

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    fill_d  = w_fill_inc;
                    idx_d   = w_first_idx;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_tap_hs) begin
                    if (tap_last) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = w_step_idx;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            fill_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            idx_q   <= idx_d;
        end
    end

endmodule

`default_nettype wire
